// File: rtl/edge_request_arbiter.sv
// Latches one-cycle request pulses and serialises them round-robin onto one
// shared resource using a valid/ready grant followed by a done-or-timeout busy phase.
module edge_request_arbiter #(
    parameter int SIGNAL_NUM    = 8,
    parameter int ID_WIDTH      = 3,
    parameter int TIMEOUT       = 255,
    parameter int TIMEOUT_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [SIGNAL_NUM-1:0] req_pulse,
    input  logic                  grant_ready,
    input  logic                  done,
    input  logic                  clear_drop,
    output logic                  grant_valid,
    output logic [ID_WIDTH-1:0]   grant_id,
    output logic [SIGNAL_NUM-1:0] grant_onehot,
    output logic                  busy,
    output logic [SIGNAL_NUM-1:0] pending,
    output logic                  drop_flag,
    output logic                  timeout
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_BUSY  = 2'd2
    } state_t;

    localparam logic [ID_WIDTH-1:0]      LAST_RST = ID_WIDTH'(SIGNAL_NUM - 1);
    localparam logic [TIMEOUT_WIDTH-1:0] TO_LAST  = TIMEOUT_WIDTH'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam logic [SIGNAL_NUM-1:0]    ONE_HOT0 = {{(SIGNAL_NUM-1){1'b0}}, 1'b1};

    state_t                   state_r, state_n;
    logic [ID_WIDTH-1:0]      grant_id_r, grant_id_n;
    logic [SIGNAL_NUM-1:0]    onehot_r, onehot_n;
    logic [ID_WIDTH-1:0]      last_id_r, last_id_n;
    logic [TIMEOUT_WIDTH-1:0] counter_r, counter_n;
    logic [SIGNAL_NUM-1:0]    pending_r, pending_n;
    logic                     grant_valid_r, busy_r, drop_r, drop_n;
    logic                     accept_s, timeout_s, pick_found_s, drop_hit_s;
    logic [ID_WIDTH-1:0]      pick_id_s;
    logic [SIGNAL_NUM-1:0]    clr_s;

    // Round-robin search: first pending bit strictly after last_id, wrapping to 0.
    always_comb begin
        pick_found_s = 1'b0;
        pick_id_s    = {ID_WIDTH{1'b0}};
        for (int k = 1; k <= SIGNAL_NUM; k++) begin
            if (!pick_found_s && pending_r[(int'(last_id_r) + k) % SIGNAL_NUM]) begin
                pick_found_s = 1'b1;
                pick_id_s    = ID_WIDTH'((int'(last_id_r) + k) % SIGNAL_NUM);
            end else begin
                pick_found_s = pick_found_s;
            end
        end
    end

    // FSM next state, grant bookkeeping and busy-phase counter.
    always_comb begin
        state_n    = state_r;
        grant_id_n = grant_id_r;
        onehot_n   = onehot_r;
        last_id_n  = last_id_r;
        counter_n  = counter_r;
        accept_s   = 1'b0;
        timeout_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (pick_found_s) begin
                    state_n    = ST_GRANT;
                    grant_id_n = pick_id_s;
                    onehot_n   = ONE_HOT0 << pick_id_s;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (grant_ready) begin
                    accept_s  = 1'b1;
                    last_id_n = grant_id_r;
                    counter_n = {TIMEOUT_WIDTH{1'b0}};
                    state_n   = ST_BUSY;
                end else begin
                    state_n = ST_GRANT;
                end
            end
            ST_BUSY: begin
                counter_n = counter_r + {{(TIMEOUT_WIDTH-1){1'b0}}, 1'b1};
                if (done) begin
                    state_n  = ST_IDLE;
                    onehot_n = {SIGNAL_NUM{1'b0}};
                end else if ((TIMEOUT != 0) && (counter_r == TO_LAST)) begin
                    timeout_s = 1'b1;
                    state_n   = ST_IDLE;
                    onehot_n  = {SIGNAL_NUM{1'b0}};
                end else begin
                    state_n = ST_BUSY;
                end
            end
            default: begin
                state_n  = ST_IDLE;
                onehot_n = {SIGNAL_NUM{1'b0}};
            end
        endcase
    end

    // A new pulse always sets its bit, so a pulse on its own accept cycle re-arms it.
    always_comb begin
        clr_s      = accept_s ? onehot_r : {SIGNAL_NUM{1'b0}};
        pending_n  = (pending_r & ~clr_s) | req_pulse;
        drop_hit_s = |(req_pulse & pending_r & ~clr_s);
        if (drop_hit_s) begin
            drop_n = 1'b1;
        end else if (clear_drop) begin
            drop_n = 1'b0;
        end else begin
            drop_n = drop_r;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= ST_IDLE;
            grant_id_r    <= {ID_WIDTH{1'b0}};
            onehot_r      <= {SIGNAL_NUM{1'b0}};
            last_id_r     <= LAST_RST;
            counter_r     <= {TIMEOUT_WIDTH{1'b0}};
            pending_r     <= {SIGNAL_NUM{1'b0}};
            drop_r        <= 1'b0;
            grant_valid_r <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            state_r       <= state_n;
            grant_id_r    <= grant_id_n;
            onehot_r      <= onehot_n;
            last_id_r     <= last_id_n;
            counter_r     <= counter_n;
            pending_r     <= pending_n;
            drop_r        <= drop_n;
            grant_valid_r <= (state_n == ST_GRANT);
            busy_r        <= (state_n == ST_BUSY);
        end
    end

    assign grant_valid  = grant_valid_r;
    assign grant_id     = grant_id_r;
    assign grant_onehot = onehot_r;
    assign busy         = busy_r;
    assign pending      = pending_r;
    assign drop_flag    = drop_r;
    // Abort is decided on the last busy cycle itself so that done can still win.
    assign timeout      = timeout_s;

endmodule

// File: tb/tb_edge_request_arbiter.sv
// Scoreboard bench: stimulus queues expected grants and per-cycle output checks;
// a single monitor process consumes and compares them at each falling edge.
module tb_edge_request_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] req_pulse = 8'h00;
    logic       grant_ready = 1'b0;
    logic       done = 1'b0;
    logic       clear_drop = 1'b0;
    logic       grant_valid;
    logic [2:0] grant_id;
    logic [7:0] grant_onehot;
    logic       busy;
    logic [7:0] pending;
    logic       drop_flag;
    logic       timeout;

    int n_cmp = 0;
    int n_bad = 0;

    int         gq[$];
    string      cq_name[$];
    int         cq_field[$];
    logic [31:0] cq_exp[$];

    localparam int F_VALID = 0, F_ID = 1, F_ONEHOT = 2, F_BUSY = 3,
                   F_PEND = 4, F_DROP = 5, F_TOUT = 6, F_GQ = 7;

    edge_request_arbiter #(
        .SIGNAL_NUM(8), .ID_WIDTH(3), .TIMEOUT(4), .TIMEOUT_WIDTH(8)
    ) dut (
        .clk(clk), .rst(rst), .req_pulse(req_pulse), .grant_ready(grant_ready),
        .done(done), .clear_drop(clear_drop), .grant_valid(grant_valid),
        .grant_id(grant_id), .grant_onehot(grant_onehot), .busy(busy),
        .pending(pending), .drop_flag(drop_flag), .timeout(timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] field_val(int f);
        case (f)
            F_VALID:  return {31'd0, grant_valid};
            F_ID:     return {29'd0, grant_id};
            F_ONEHOT: return {24'd0, grant_onehot};
            F_BUSY:   return {31'd0, busy};
            F_PEND:   return {24'd0, pending};
            F_DROP:   return {31'd0, drop_flag};
            F_TOUT:   return {31'd0, timeout};
            F_GQ:     return 32'(gq.size());
            default:  return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Monitor: checks every accepted grant against the queue, then drains cycle checks.
    initial begin
        int          e;
        string       nm;
        int          f;
        logic [31:0] x;
        forever begin
            @(negedge clk);
            if (grant_valid && grant_ready) begin
                n_cmp++;
                if (gq.size() == 0) begin
                    n_bad++;
                    $display("FAIL grant_accept: got id %0d, expected no grant", grant_id);
                end else begin
                    e = gq.pop_front();
                    if (32'(grant_id) != e) begin
                        n_bad++;
                        $display("FAIL grant_accept: got id %0d, expected %0d", grant_id, e);
                    end
                end
            end
            while (cq_name.size() > 0) begin
                nm = cq_name.pop_front();
                f  = cq_field.pop_front();
                x  = cq_exp.pop_front();
                n_cmp++;
                if (field_val(f) !== x) begin
                    n_bad++;
                    $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, field_val(f), x, $time);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int f, input logic [31:0] x);
        cq_name.push_back(nm);
        cq_field.push_back(f);
        cq_exp.push_back(x);
    endtask

    task automatic chk_idle_zero(input string nm);
        chk({nm, "_valid"}, F_VALID, 32'd0);
        chk({nm, "_id"}, F_ID, 32'd0);
        chk({nm, "_onehot"}, F_ONEHOT, 32'd0);
        chk({nm, "_busy"}, F_BUSY, 32'd0);
        chk({nm, "_pending"}, F_PEND, 32'd0);
        chk({nm, "_drop"}, F_DROP, 32'd0);
        chk({nm, "_timeout"}, F_TOUT, 32'd0);
    endtask

    // Waits (bounded) for a grant, accepts it, then ends the busy phase with done.
    task automatic serve(input string nm);
        int k;
        for (k = 0; k < 20 && !grant_valid; k++) tick();
        if (!grant_valid) begin
            chk({nm, "_wait_valid"}, F_VALID, 32'd1);
            tick();
        end else begin
            grant_ready = 1'b1;
            tick();
            grant_ready = 1'b0;
            done = 1'b1;
            tick();
            done = 1'b0;
        end
    endtask

    task automatic pulse(input logic [7:0] v);
        req_pulse = v;
        tick();
        req_pulse = 8'h00;
    endtask

    initial begin
        // Reset state
        rst = 1'b0;
        tick();
        tick();
        chk_idle_zero("reset");
        rst = 1'b1;
        tick();

        // 1: single request latency
        gq.push_back(0);
        pulse(8'h01);
        chk("t1_pending", F_PEND, 32'h01);
        chk("t1_valid_t1", F_VALID, 32'd0);
        tick();
        chk("t1_valid", F_VALID, 32'd1);
        chk("t1_id", F_ID, 32'd0);
        chk("t1_onehot", F_ONEHOT, 32'h01);
        tick();
        grant_ready = 1'b1;
        tick();
        grant_ready = 1'b0;
        chk("t1_busy", F_BUSY, 32'd1);
        chk("t1_pending_clr", F_PEND, 32'h00);
        chk("t1_valid_off", F_VALID, 32'd0);
        chk("t1_busy_onehot", F_ONEHOT, 32'h01);
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("t1_idle_busy", F_BUSY, 32'd0);
        chk("t1_idle_onehot", F_ONEHOT, 32'h00);

        // 2: fresh reset, 0 then 7, then wrap gives 0 after 7 again
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        gq.push_back(0); gq.push_back(7);
        pulse(8'h81);
        chk("t2_pending", F_PEND, 32'h81);
        serve("t2a");
        serve("t2b");
        gq.push_back(0); gq.push_back(7);
        pulse(8'h81);
        serve("t2c");
        serve("t2d");

        // 3: grant 3 held without ready; duplicate pulse is dropped
        gq.push_back(3);
        pulse(8'h08);
        tick();
        for (int i = 0; i < 10; i++) begin
            chk("t3_hold_valid", F_VALID, 32'd1);
            chk("t3_hold_id", F_ID, 32'd3);
            if (i == 3) req_pulse = 8'h08;
            else        req_pulse = 8'h00;
            tick();
        end
        req_pulse = 8'h00;
        chk("t3_drop", F_DROP, 32'd1);
        chk("t3_pending", F_PEND, 32'h08);
        clear_drop = 1'b1;
        req_pulse = 8'h08;
        tick();
        req_pulse = 8'h00;
        chk("t3_drop_wins", F_DROP, 32'd1);
        tick();
        clear_drop = 1'b0;
        chk("t3_drop_cleared", F_DROP, 32'd0);
        serve("t3");

        // 4: timeout on 4th busy cycle, then done on that cycle suppresses it
        for (int r = 0; r < 2; r++) begin
            gq.push_back(2);
            pulse(8'h04);
            tick();
            grant_ready = 1'b1;
            tick();
            grant_ready = 1'b0;
            chk("t4_busy1", F_BUSY, 32'd1);
            chk("t4_tout1", F_TOUT, 32'd0);
            tick();
            tick();
            chk("t4_busy3", F_BUSY, 32'd1);
            chk("t4_tout3", F_TOUT, 32'd0);
            tick();
            if (r == 1) done = 1'b1;
            chk("t4_busy4", F_BUSY, 32'd1);
            chk("t4_tout4", F_TOUT, (r == 0) ? 32'd1 : 32'd0);
            tick();
            done = 1'b0;
            chk("t4_after_busy", F_BUSY, 32'd0);
            chk("t4_after_tout", F_TOUT, 32'd0);
            chk("t4_after_valid", F_VALID, 32'd0);
        end

        // 5: pulse on own accept cycle re-arms the request
        gq.push_back(5);
        pulse(8'h20);
        tick();
        grant_ready = 1'b1;
        req_pulse = 8'h20;
        tick();
        grant_ready = 1'b0;
        req_pulse = 8'h00;
        chk("t5_pending", F_PEND, 32'h20);
        chk("t5_busy", F_BUSY, 32'd1);
        chk("t5_nodrop", F_DROP, 32'd0);
        gq.push_back(5);
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        chk("t5_regrant_valid", F_VALID, 32'd1);
        chk("t5_regrant_id", F_ID, 32'd5);
        serve("t5");

        // 6: reset while busy with pending F0
        gq.push_back(3);
        pulse(8'h08);
        tick();
        grant_ready = 1'b1;
        tick();
        grant_ready = 1'b0;
        pulse(8'hF0);
        chk("t6_pending", F_PEND, 32'hF0);
        chk("t6_busy", F_BUSY, 32'd1);
        tick();
        rst = 1'b0;
        #1;
        chk_idle_zero("t6_rst");
        tick();
        rst = 1'b1;
        tick();
        gq.push_back(2);
        pulse(8'h04);
        tick();
        chk("t6_valid", F_VALID, 32'd1);
        chk("t6_id", F_ID, 32'd2);
        serve("t6");

        tick();
        chk("all_grants_seen", F_GQ, 32'd0);
        tick();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
